// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RV32I datapath: one state per cycle, outputs decoded from state.
// Optional CTRL_FETCH_WAIT_EN inserts a FETCH_WAIT state ahead of every FETCH for synchronous imem latency.
module multicycle_control_fsm #(
`ifdef CTRL_FETCH_WAIT_EN
    parameter int unsigned STATE_W = 5
`else
    parameter int unsigned STATE_W = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op_code,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    input  logic               Zero,
    output logic               adr_src,
    output logic               mem_write,
    output logic               IR_write,
    output logic               reg_write,
    output logic               PC_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         imm_src,
    output logic [3:0]         alu_control,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH      = STATE_W'(0),
        S_DECODE     = STATE_W'(1),
        S_MEMADR     = STATE_W'(2),
        S_MEMREAD    = STATE_W'(3),
        S_MEMWB      = STATE_W'(4),
        S_MEMWRITE   = STATE_W'(5),
        S_EXEC_R     = STATE_W'(6),
        S_EXEC_I     = STATE_W'(7),
        S_ALUWB      = STATE_W'(8),
        S_BRANCH     = STATE_W'(9),
        S_JAL        = STATE_W'(10),
        S_JALR_ADR   = STATE_W'(11),
        S_JALR_PC    = STATE_W'(12),
        S_LUI        = STATE_W'(13),
        S_AUIPC      = STATE_W'(14),
`ifdef CTRL_FETCH_WAIT_EN
        S_TRAP       = STATE_W'(15),
        S_FETCH_WAIT = STATE_W'(16)
`else
        S_TRAP       = STATE_W'(15)
`endif
    } state_t;

`ifdef CTRL_FETCH_WAIT_EN
    localparam state_t S_NEXT_FETCH = S_FETCH_WAIT;
`else
    localparam state_t S_NEXT_FETCH = S_FETCH;
`endif

    state_t state_q;
    state_t state_d;

    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // Shared R/I op map; alt selects SUB at 000 and SRA at 101.
    function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_NEXT_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        IR_write    = 1'b0;
        reg_write   = 1'b0;
        PC_write    = 1'b0;
        result_src  = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        imm_src     = IMM_I;
        alu_control = ALU_ADD;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                IR_write   = 1'b1;
                PC_write   = 1'b1;
                result_src = 2'd2;
                alu_src_b  = 2'd2;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                // Branch/JAL target precomputed into ALU_out from old_PC + imm.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = (op_code == OP_JAL) ? IMM_J : IMM_B;
                case (op_code)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = (op_code == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'd1;
                reg_write  = 1'b1;
                state_d    = S_NEXT_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = S_NEXT_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'd2;
                alu_control = arith_op(funct3, funct7[5]);
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'd2;
                alu_src_b   = 2'd1;
                alu_control = arith_op(funct3, funct7[5] && (funct3 != 3'b000));
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_NEXT_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                state_d   = S_NEXT_FETCH;
                case (funct3)
                    3'b000: begin alu_control = ALU_SUB;  PC_write = Zero;  end
                    3'b001: begin alu_control = ALU_SUB;  PC_write = !Zero; end
                    3'b100: begin alu_control = ALU_SLT;  PC_write = !Zero; end
                    3'b101: begin alu_control = ALU_SLT;  PC_write = Zero;  end
                    3'b110: begin alu_control = ALU_SLTU; PC_write = !Zero; end
                    3'b111: begin alu_control = ALU_SLTU; PC_write = Zero;  end
                    default: state_d = S_TRAP;
                endcase
            end
            S_JAL: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                PC_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                state_d   = S_JALR_PC;
            end
            S_JALR_PC: begin
                // PC takes rs1+imm from ALU_out while the ALU forms the link value.
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                PC_write  = 1'b1;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b   = 2'd1;
                imm_src     = IMM_U;
                alu_control = ALU_PASSB;
                state_d     = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
`ifdef CTRL_FETCH_WAIT_EN
            S_FETCH_WAIT: begin
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_NEXT_FETCH;
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expected cycle traces built from
// RV32I instruction classes, randomized instructions and branch operands. Honors CTRL_FETCH_WAIT_EN.
module tb_multicycle_control_fsm;

`ifdef CTRL_FETCH_WAIT_EN
    localparam int unsigned SW = 5;
`else
    localparam int unsigned SW = 4;
`endif

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXEC_R = 6, ST_EXEC_I = 7, ST_ALUWB = 8, ST_BRANCH = 9;
    localparam int ST_JAL = 10, ST_JALR_ADR = 11, ST_JALR_PC = 12, ST_LUI = 13, ST_AUIPC = 14;
    localparam int ST_TRAP = 15, ST_FETCH_WAIT = 16;
`ifdef CTRL_FETCH_WAIT_EN
    localparam int ST_RESET = ST_FETCH_WAIT;
`else
    localparam int ST_RESET = ST_FETCH;
`endif

    typedef struct packed {
        logic [4:0] st;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       pcw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       ill;
    } exp_t;

    logic          clk, reset;
    logic [6:0]    op_code, funct7;
    logic [2:0]    funct3;
    logic          Zero;
    logic          adr_src, mem_write, IR_write, reg_write, PC_write, illegal;
    logic [1:0]    result_src, alu_src_a, alu_src_b;
    logic [2:0]    imm_src;
    logic [3:0]    alu_control;
    logic [SW-1:0] state_dbg;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .adr_src(adr_src), .mem_write(mem_write), .IR_write(IR_write), .reg_write(reg_write),
        .PC_write(PC_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int st, input logic adr, input logic mw, input logic irw,
                                input logic rw, input logic pcw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b, input logic [2:0] imm,
                                input logic [3:0] alu, input logic ill);
        exp_t e;
        e.st = 5'(st); e.adr = adr; e.mw = mw; e.irw = irw; e.rw = rw; e.pcw = pcw;
        e.rs = rs; e.a = a; e.b = b; e.imm = imm; e.alu = alu; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t observe();
        return {5'(state_dbg), adr_src, mem_write, IR_write, reg_write, PC_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal};
    endfunction

    // ALU operation an R/I instruction needs, from its RV32I mnemonic.
    function automatic logic [3:0] want_alu(input logic [2:0] f3, input logic f7b5, input logic is_imm);
        case (f3)
            3'd0: return (!is_imm && f7b5) ? 4'b0001 : 4'b0000;
            3'd1: return 4'b0101;
            3'd2: return 4'b1000;
            3'd3: return 4'b1001;
            3'd4: return 4'b0100;
            3'd5: return f7b5 ? 4'b0111 : 4'b0110;
            3'd6: return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    // Real branch semantics on operands; Zero is what the datapath ALU would flag.
    task automatic branch_eval(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                               output logic z, output logic tk, output logic [3:0] alu);
        logic [31:0] res;
        logic slt, sltu;
        slt  = $signed(x) < $signed(y);
        sltu = x < y;
        case (f3)
            3'd0, 3'd1: begin res = x - y;          alu = 4'b0001; end
            3'd4, 3'd5: begin res = 32'(slt);       alu = 4'b1000; end
            default:    begin res = 32'(sltu);      alu = 4'b1001; end
        endcase
        z = (res == 32'd0);
        case (f3)
            3'd0: tk = (x == y);
            3'd1: tk = (x != y);
            3'd4: tk = slt;
            3'd5: tk = !slt;
            3'd6: tk = sltu;
            default: tk = !sltu;
        endcase
    endtask

    task automatic push_fetch(input logic [6:0] op);
`ifdef CTRL_FETCH_WAIT_EN
        exp_q.push_back(mk(ST_FETCH_WAIT, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
`endif
        exp_q.push_back(mk(ST_FETCH, 0, 0, 1, 0, 1, 2'd2, 2'd0, 2'd2, 3'd0, 4'd0, 0));
        exp_q.push_back(mk(ST_DECODE, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1,
                           (op == 7'b1101111) ? 3'b011 : 3'b010, 4'd0, 0));
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back(mk(ST_TRAP, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1));
    endtask

    // Expected cycle trace of one legal instruction; unknown opcodes trap for n_trap cycles.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic taken, input logic [3:0] br_alu, input int n_trap);
        exp_t wb;
        wb = mk(ST_ALUWB, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
        push_fetch(op);
        case (op)
            7'b0000011: begin
                exp_q.push_back(mk(ST_MEMADR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'b000, 4'd0, 0));
                exp_q.push_back(mk(ST_MEMREAD, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
                exp_q.push_back(mk(ST_MEMWB, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 3'd0, 4'd0, 0));
            end
            7'b0100011: begin
                exp_q.push_back(mk(ST_MEMADR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'b001, 4'd0, 0));
                exp_q.push_back(mk(ST_MEMWRITE, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
            end
            7'b0110011: begin
                exp_q.push_back(mk(ST_EXEC_R, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd0,
                                   want_alu(f3, f7[5], 1'b0), 0));
                exp_q.push_back(wb);
            end
            7'b0010011: begin
                exp_q.push_back(mk(ST_EXEC_I, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0,
                                   want_alu(f3, f7[5], 1'b1), 0));
                exp_q.push_back(wb);
            end
            7'b1100011: begin
                exp_q.push_back(mk(ST_BRANCH, 0, 0, 0, 0, taken, 2'd0, 2'd2, 2'd0, 3'd0, br_alu, 0));
                if (f3 == 3'd2 || f3 == 3'd3) push_trap(n_trap);
            end
            7'b1101111: begin
                exp_q.push_back(mk(ST_JAL, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0, 0));
                exp_q.push_back(wb);
            end
            7'b1100111: begin
                exp_q.push_back(mk(ST_JALR_ADR, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 4'd0, 0));
                exp_q.push_back(mk(ST_JALR_PC, 0, 0, 0, 0, 1, 2'd0, 2'd1, 2'd2, 3'd0, 4'd0, 0));
                exp_q.push_back(wb);
            end
            7'b0110111: begin
                exp_q.push_back(mk(ST_LUI, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 3'b100, 4'b1010, 0));
                exp_q.push_back(wb);
            end
            7'b0010111: begin
                exp_q.push_back(mk(ST_AUIPC, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'b100, 4'd0, 0));
                exp_q.push_back(wb);
            end
            default: push_trap(n_trap);
        endcase
    endtask

    // Entered at a negedge where the DUT sits in the first queued state; leaves one negedge past the last.
    task automatic run_seq(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
        int step;
        exp_t e, obs;
        step = 0;
        op_code = op; funct3 = f3; funct7 = f7; Zero = z;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            obs = observe();
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s step %0d: got %h want %h", name, step, obs, e);
            end
            step++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (state_dbg !== SW'(ST_RESET) || illegal !== 1'b0 || PC_write !== 1'b1 && ST_RESET == ST_FETCH) begin
            bad++;
            $display("FAIL reset_state: got st=%0d ill=%b pcw=%b want st=%0d ill=0", state_dbg, illegal, PC_write, ST_RESET);
        end
    endtask

    task automatic test_r_sub();
        build(7'b0110011, 3'b000, 7'b0100000, 1'b0, 4'd0, 0);
        run_seq("r_sub", 7'b0110011, 3'b000, 7'b0100000, 1'b0);
    endtask

    task automatic test_load();
        build(7'b0000011, 3'b010, 7'd0, 1'b0, 4'd0, 0);
        run_seq("load", 7'b0000011, 3'b010, 7'd0, 1'b1);
    endtask

    task automatic test_branch_bne();
        build(7'b1100011, 3'b001, 7'd0, 1'b1, 4'b0001, 0);
        run_seq("bne_taken", 7'b1100011, 3'b001, 7'd0, 1'b0);
        build(7'b1100011, 3'b001, 7'd0, 1'b0, 4'b0001, 0);
        run_seq("bne_not_taken", 7'b1100011, 3'b001, 7'd0, 1'b1);
    endtask

    task automatic test_jalr();
        build(7'b1100111, 3'b000, 7'd0, 1'b0, 4'd0, 0);
        run_seq("jalr", 7'b1100111, 3'b000, 7'd0, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [2:0] br_f3 [6];
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [31:0] x, y;
        logic z, tk;
        logic [3:0] balu;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 8)];
            f3 = 3'($urandom);
            f7 = 7'($urandom);
            z  = 1'($urandom);
            tk = 1'b0;
            balu = 4'd0;
            if (op == 7'b1100011) begin
                f3 = br_f3[$urandom_range(0, 5)];
                x  = $urandom;
                y  = ($urandom_range(0, 2) == 0) ? x : $urandom;
                branch_eval(f3, x, y, z, tk, balu);
            end
            build(op, f3, f7, tk, balu, 0);
            run_seq("random", op, f3, f7, z);
        end
    endtask

    task automatic test_reset_mid_store();
        exp_t e;
        build(7'b0100011, 3'b010, 7'd0, 1'b0, 4'd0, 0);
        e = exp_q.pop_back();
        run_seq("store_pre", 7'b0100011, 3'b010, 7'd0, 1'b0);
        #1;
        total++;
        if (observe() !== e) begin
            bad++;
            $display("FAIL store_memwrite: got %h want %h", observe(), e);
        end
        do_reset();
        #1;
        total++;
        if (state_dbg !== SW'(ST_RESET) || mem_write !== 1'b0 || illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_store: got st=%0d mw=%b ill=%b want st=%0d mw=0 ill=0",
                     state_dbg, mem_write, illegal, ST_RESET);
        end
    endtask

    task automatic test_trap();
        logic [6:0] op;
        build(7'b1111111, 3'd0, 7'd0, 1'b0, 4'd0, 20);
        run_seq("trap_7f", 7'b1111111, 3'd0, 7'd0, 1'b0);
        do_reset();
        test_reset();
        for (int n = 0; n < 4; n++) begin
            do begin
                op = 7'($urandom);
            end while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111});
            build(op, 3'($urandom), 7'($urandom), 1'b0, 4'd0, 5);
            run_seq("trap_rand", op, 3'($urandom), 7'($urandom), 1'($urandom));
            do_reset();
            test_reset();
        end
    endtask

    task automatic test_branch_bad_funct3();
        build(7'b1100011, 3'b011, 7'd0, 1'b0, 4'd0, 4);
        run_seq("branch_f3_011", 7'b1100011, 3'b011, 7'd0, 1'b1);
        do_reset();
        test_reset();
    endtask

    initial begin
        reset = 1'b1;
        op_code = 7'd0; funct3 = 3'd0; funct7 = 7'd0; Zero = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_r_sub();
        test_load();
        test_branch_bne();
        test_jalr();
        test_random();
        test_reset_mid_store();
        test_trap();
        test_branch_bad_funct3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit sitting directly upstream of the multicycle RV32I datapath.
- Consumes op_code/funct3/funct7/Zero from the datapath and drives every datapath control strobe and select, one FSM state per cycle.
- Supported instructions: RV32I loads, stores, R-type, I-type ALU, branches, JAL, JALR, LUI and AUIPC.
- Any other opcode parks the FSM in a sticky trap state.

Parameters:
- STATE_W, 4, width of the state register (one-hot not used; binary encoding).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- op_code  in  7  instruction [6:0] from the instruction register
- funct3  in  3  instruction [14:12]
- funct7  in  7  instruction [31:25]
- Zero  in  1  ALU zero flag (combinational, current cycle)
- adr_src  out  1  0=PC, 1=result
- mem_write  out  1  data memory write strobe
- IR_write  out  1  instruction register / old_PC load enable
- reg_write  out  1  register file write enable
- PC_write  out  1  PC load enable
- result_src  out  2  0=ALU_out, 1=mem data, 2=ALU_result
- alu_src_a  out  2  0=PC, 1=old_PC, 2=rs1 flop
- alu_src_b  out  2  0=rs2 flop, 1=immediate, 2=constant 4
- imm_src  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- alu_control  out  4  see Behaviour
- illegal  out  1  sticky: unsupported opcode decoded
- state_dbg  out  STATE_W  current state, for trace

Behaviour:
- One clock (clk). Reset is synchronous, active-high. On reset the state becomes FETCH and illegal clears; reset overrides any in-progress instruction.
- Outputs are Moore/Mealy combinational from the state. Every output not listed for a state is 0. The exception is imm_src, which holds 000 unless stated.
- alu_control encodings:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU
  - 1010 PASSB (result = SrcB)
- States and transitions:
  - FETCH: adr_src=0, IR_write=1, a=0, b=2, ADD, result_src=2, PC_write=1. Next state is DECODE.
  - DECODE: a=1, b=1, ADD. imm_src is J for opcode 1101111 and B otherwise; this precomputes the target in ALU_out.
    - Next state by op_code: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR_ADR; 0110111 -> LUI; 0010111 -> AUIPC.
    - Any other opcode -> TRAP.
  - MEMADR: a=2, b=1, ADD. imm_src is S for stores and I for loads. Next state is MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: adr_src=1, result_src=0. Next state is MEMWB.
  - MEMWB: result_src=1, reg_write=1. Next state is FETCH.
  - MEMWRITE: adr_src=1, result_src=0, mem_write=1. Next state is FETCH.
  - EXEC_R: a=2, b=0, ALU op from funct3/funct7[5]: 000 ADD or SUB (f7[5]=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL or SRA (f7[5]=1), 110 OR, 111 AND. Next state is ALUWB.
  - EXEC_I: a=2, b=1, imm I. Same op map, with two differences: funct3=000 is always ADD, and funct3=101 uses f7[5] for SRAI. Next state is ALUWB.
  - ALUWB: result_src=0, reg_write=1. Next state is FETCH.
  - BRANCH: a=2, b=0, result_src=0. ALU op and taken condition by funct3:
    - 000 SUB, taken when Zero=1
    - 001 SUB, taken when Zero=0
    - 100 SLT, taken when Zero=0
    - 101 SLT, taken when Zero=1
    - 110 SLTU, taken when Zero=0
    - 111 SLTU, taken when Zero=1
    - PC_write=taken. Funct3 010/011 -> TRAP. Otherwise next state is FETCH.
  - JAL: a=1, b=2, ADD, result_src=0, PC_write=1. Next state is ALUWB (writes old_PC+4).
  - JALR_ADR: a=2, b=1, imm I, ADD. Next state is JALR_PC.
  - JALR_PC: a=1, b=2, ADD, result_src=0, PC_write=1. Next state is ALUWB.
  - LUI: b=1, imm U, PASSB. Next state is ALUWB.
  - AUIPC: a=1, b=1, imm U, ADD. Next state is ALUWB.
  - TRAP: all strobes 0, illegal=1. Holds until reset.
- CPI is 3 for branch, 4 for R/I/JAL/LUI/AUIPC/store, 5 for load and JALR (+1 each with the optional feature).
- No write strobe (mem_write, reg_write, PC_write, IR_write) is ever asserted in two consecutive states for the same instruction except FETCH (IR_write, PC_write).

Optional Feature:
- CTRL_FETCH_WAIT_EN: when defined, adds a FETCH_WAIT state entered from reset and from every state that would go to FETCH.
  - FETCH_WAIT drives adr_src=0 with all strobes 0, then goes to FETCH. This absorbs the synchronous instruction memory read latency.
  - Reset goes to FETCH_WAIT.
- When undefined, FETCH is entered directly and FETCH_WAIT does not exist.

Test Plan:
- Reset mid-MEMWRITE (reset=1 for 1 cycle) -> next cycle state_dbg=FETCH, mem_write=0, illegal=0.
- op_code=0110011, funct3=000, funct7=0100000 -> states FETCH,DECODE,EXEC_R,ALUWB; alu_control=0001 in EXEC_R; reg_write=1 only in ALUWB.
- op_code=0000011 -> MEMADR(imm_src=000),MEMREAD(adr_src=1),MEMWB(result_src=01,reg_write=1), then FETCH.
- op_code=1100011, funct3=001, Zero=0 -> PC_write=1 in BRANCH. Same instruction with Zero=1 -> PC_write=0. Both return to FETCH.
- op_code=1100111 -> JALR_ADR, JALR_PC (PC_write=1,result_src=00), ALUWB (reg_write=1).
- op_code=1111111 -> TRAP, illegal=1 held for 20 cycles with all strobes 0; cleared only by reset.
